// File: rtl/fir_pkg.sv
// Shared types, widths and the round/saturate helper for the FIR output datapath.
package fir_pkg;

   localparam int unsigned ACC_W      = 56;
   localparam int unsigned OUT_W      = 32;
   localparam int unsigned FRAC_SHIFT = 24;
   localparam int unsigned CALC_W     = 128;

   typedef struct packed {
      logic signed [OUT_W-1:0] i;
      logic signed [OUT_W-1:0] q;
   } iq_sample_t;

   typedef struct packed {
      logic                     sat;
      logic signed [CALC_W-1:0] val;
   } rs_t;

   // Round-half-up then arithmetic shift; clamps to out_w bits when sat_en, else the caller
   // keeps the low out_w bits. x must be sign-extended to CALC_W.
   function automatic rs_t round_sat(input logic signed [CALC_W-1:0] x,
                                     input int unsigned frac,
                                     input int unsigned out_w,
                                     input logic sat_en);
      logic signed [CALC_W-1:0] half;
      logic signed [CALC_W-1:0] lim;
      logic signed [CALC_W-1:0] hi;
      logic signed [CALC_W-1:0] lo;
      logic signed [CALC_W-1:0] r;
      rs_t res;
      half = CALC_W'(1) << (frac - 1);
      lim  = CALC_W'(1) << (out_w - 1);
      hi   = lim + '1;
      lo   = -lim;
      r    = (x + half) >>> frac;
      res.sat = 1'b0;
      res.val = r;
      if (sat_en) begin
         if (r > hi) begin
            res.val = hi;
            res.sat = 1'b1;
         end else if (r < lo) begin
            res.val = lo;
            res.sat = 1'b1;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/fir_out_fifo.sv
// Generic synchronous first-word-fall-through FIFO; reads as zero while empty.
module fir_out_fifo #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       wdata,
   output logic [WIDTH-1:0]       rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);
   import fir_pkg::*;

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == FULL_CNT);
   assign level   = count_q;
   assign do_pop  = pop & ~empty;
   // A full FIFO still accepts a write when the head leaves on the same edge.
   assign do_push = push & (~full | do_pop);
   assign rdata   = empty ? '0 : mem[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_q] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         if (do_push && !do_pop) begin
            count_q <= count_q + (AW + 1)'(1);
         end else if (!do_push && do_pop) begin
            count_q <= count_q - (AW + 1)'(1);
         end
      end
   end

endmodule

// File: rtl/fir_out_stage.sv
// FIR output conditioning: round, saturate (FIR_OUT_SAT_EN) or wrap, then queue in an FWFT FIFO.
// Overflow drops the sample and raises a sticky flag since the accumulator cannot stall.
module fir_out_stage #(
   parameter int unsigned IN_W       = fir_pkg::ACC_W,
   parameter int unsigned OUT_W      = fir_pkg::OUT_W,
   parameter int unsigned FRAC_SHIFT = fir_pkg::FRAC_SHIFT,
   parameter int unsigned DEPTH      = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   pushIn,
   input  logic [IN_W-1:0]        inI,
   input  logic [IN_W-1:0]        inQ,
   output logic                   outValid,
   input  logic                   outReady,
   output logic [OUT_W-1:0]       outI,
   output logic [OUT_W-1:0]       outQ,
   output logic [$clog2(DEPTH):0] level,
   output logic                   ovfFlag,
   output logic                   satFlag
);
   import fir_pkg::*;

`ifdef FIR_OUT_SAT_EN
   localparam logic SAT_EN = 1'b1;
`else
   localparam logic SAT_EN = 1'b0;
`endif

   logic                      r_valid_q;
   logic [IN_W-1:0]           r_i_q;
   logic [IN_W-1:0]           r_q_q;
   logic                      s_valid_q;
   logic [OUT_W-1:0]          s_i_q;
   logic [OUT_W-1:0]          s_q_q;
   logic                      s_sat_q;
   logic                      ovf_q;
   logic                      sat_q;
   rs_t                       rs_i;
   rs_t                       rs_q;
   logic [CALC_W-OUT_W-1:0]   unused_hi_i;
   logic [CALC_W-OUT_W-1:0]   unused_hi_q;
   logic                      full;
   logic                      empty;
   logic                      pop;

   always_comb begin
      rs_i = round_sat(CALC_W'($signed(r_i_q)), FRAC_SHIFT, OUT_W, SAT_EN);
      rs_q = round_sat(CALC_W'($signed(r_q_q)), FRAC_SHIFT, OUT_W, SAT_EN);
   end

   // Upper bits are discarded: clamped values fit, wrapped values are meant to wrap.
   assign unused_hi_i = rs_i.val[CALC_W-1:OUT_W];
   assign unused_hi_q = rs_q.val[CALC_W-1:OUT_W];

   assign outValid = ~empty;
   assign pop      = outValid & outReady;
   assign ovfFlag  = ovf_q;
   assign satFlag  = sat_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid_q <= 1'b0;
         s_valid_q <= 1'b0;
         ovf_q     <= 1'b0;
         sat_q     <= 1'b0;
      end else begin
         r_valid_q <= pushIn;
         s_valid_q <= r_valid_q;
         if (pushIn) begin
            r_i_q <= inI;
            r_q_q <= inQ;
         end
         if (r_valid_q) begin
            s_i_q   <= rs_i.val[OUT_W-1:0];
            s_q_q   <= rs_q.val[OUT_W-1:0];
            s_sat_q <= rs_i.sat | rs_q.sat;
         end
         if (s_valid_q) begin
            sat_q <= sat_q | s_sat_q;
            if (full && !pop) begin
               ovf_q <= 1'b1;
            end
         end
      end
   end

   fir_out_fifo #(
      .WIDTH (2 * OUT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (s_valid_q),
      .pop   (pop),
      .wdata ({s_i_q, s_q_q}),
      .rdata ({outI, outQ}),
      .full  (full),
      .empty (empty),
      .level (level)
   );

endmodule

// File: tb/tb_fir_out_stage.sv
// Bench for fir_out_stage: directed scenarios plus random traffic against a queue-based model.
module tb_fir_out_stage;
   import fir_pkg::*;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        pushIn;
   logic [55:0] inI;
   logic [55:0] inQ;
   logic        outValid;
   logic        outReady;
   logic [31:0] outI;
   logic [31:0] outQ;
   logic [3:0]  level;
   logic        ovfFlag;
   logic        satFlag;

   always #5 clk = ~clk;

   fir_out_stage dut (
      .clk      (clk),
      .reset    (reset),
      .pushIn   (pushIn),
      .inI      (inI),
      .inQ      (inQ),
      .outValid (outValid),
      .outReady (outReady),
      .outI     (outI),
      .outQ     (outQ),
      .level    (level),
      .ovfFlag  (ovfFlag),
      .satFlag  (satFlag)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: delay line of two edges feeding a bounded queue.
   iq_sample_t mq[$];
   iq_sample_t d1, d2;
   bit         d1_v, d2_v, d1_s, d2_s;
   bit         m_ovf, m_sat;

   function automatic logic [31:0] ref_rail(input logic [55:0] raw, output bit sat);
      longint x, r;
      x   = longint'($signed(raw));
      // floor(x / 2^24 + 1/2)
      r   = (x + 64'sd8388608) >>> 24;
      sat = 1'b0;
`ifdef FIR_OUT_SAT_EN
      if (r > 64'sd2147483647) begin
         sat = 1'b1;
         return 32'h7fffffff;
      end
      if (r < -64'sd2147483648) begin
         sat = 1'b1;
         return 32'h80000000;
      end
`endif
      return r[31:0];
   endfunction

   task automatic model_edge();
      bit si, sq;
      if (reset) begin
         mq.delete();
         d1_v  = 1'b0;
         d2_v  = 1'b0;
         m_ovf = 1'b0;
         m_sat = 1'b0;
         return;
      end
      if (mq.size() != 0 && outReady) void'(mq.pop_front());
      if (d2_v) begin
         m_sat = m_sat | d2_s;
         if (mq.size() < DEPTH) mq.push_back(d2);
         else m_ovf = 1'b1;
      end
      d2   = d1;
      d2_v = d1_v;
      d2_s = d1_s;
      d1_v = pushIn;
      if (pushIn) begin
         d1.i = ref_rail(inI, si);
         d1.q = ref_rail(inQ, sq);
         d1_s = si | sq;
      end
   endtask

   task automatic compare_all();
      logic [31:0] ei, eq;
      ei = (mq.size() != 0) ? mq[0].i : 32'h0;
      eq = (mq.size() != 0) ? mq[0].q : 32'h0;
      check_val("level", level, mq.size());
      check_val("outValid", outValid, mq.size() != 0);
      check_val("outI", outI, ei);
      check_val("outQ", outQ, eq);
      check_val("ovfFlag", ovfFlag, m_ovf);
      check_val("satFlag", satFlag, m_sat);
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all();
   endtask

   task automatic drive(input bit p, input logic [55:0] vi, input logic [55:0] vq, input bit rdy);
      pushIn   = p;
      inI      = vi;
      inQ      = vq;
      outReady = rdy;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   function automatic logic [55:0] scaled(input int k);
      return 56'(k) << 24;
   endfunction

   function automatic logic [55:0] rnd56();
      logic [63:0] w;
      w = {$urandom, $urandom};
      case ($urandom_range(0, 3))
         0: return w[55:0];
         1: return {{15{w[40]}}, w[40:0]};
         2: return {{8{w[47]}}, w[47:24], 24'h800000};
         default: return w[0] ? {1'b0, {31{1'b1}}, w[23:0]} : {1'b1, 31'b0, w[23:0]};
      endcase
   endfunction

   initial begin
      drive(1'b0, '0, '0, 1'b0);
      reset = 1'b1;
      tick();
      // pushIn on a reset edge must be ignored
      pushIn = 1'b1;
      tick();
      reset  = 1'b0;
      pushIn = 1'b0;
      check_val("rst_level", level, 0);
      check_val("rst_valid", outValid, 0);
      check_val("rst_outI", outI, 0);
      check_val("rst_flags", {ovfFlag, satFlag}, 0);
      tick();
      tick();
      check_val("rst_push_ignored", outValid, 0);

      // Rounding ties: +1.5 -> 2, -1.5 -> -1, visible two edges after push
      drive(1'b1, 56'h1800000, -56'sh1800000, 1'b0);
      tick();
      drive(1'b0, '0, '0, 1'b0);
      tick();
      check_val("round_lat_e1", outValid, 0);
      tick();
      check_val("round_lat_e2", outValid, 1);
      check_val("round_i", outI, 32'd2);
      check_val("round_q", outQ, 32'hffffffff);
      check_val("round_sat", satFlag, 0);
      outReady = 1'b1;
      tick();

      // Full-scale inputs
      drive(1'b1, {1'b0, {55{1'b1}}}, {1'b1, 55'b0}, 1'b0);
      tick();
      drive(1'b0, '0, '0, 1'b0);
      tick();
      tick();
      check_val("sat_q", outQ, 32'h80000000);
`ifdef FIR_OUT_SAT_EN
      check_val("sat_i", outI, 32'h7fffffff);
      check_val("sat_flag", satFlag, 1);
`else
      check_val("wrap_i", outI, 32'h80000000);
      check_val("wrap_flag", satFlag, 0);
`endif
      do_reset();

      // Overflow: nine pushes into an eight-deep FIFO with no consumer
      for (int k = 1; k <= 9; k++) begin
         drive(1'b1, scaled(k), -scaled(k), 1'b0);
         tick();
      end
      drive(1'b0, '0, '0, 1'b0);
      tick();
      tick();
      check_val("ovf_level", level, 8);
      check_val("ovf_flag", ovfFlag, 1);
      outReady = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         check_val("ovf_drain", outI, k);
         tick();
      end
      check_val("ovf_empty", outValid, 0);
      do_reset();

      // Full with simultaneous pop: level held at DEPTH, nothing dropped
      for (int k = 0; k < 8; k++) begin
         drive(1'b1, scaled(10 + k), scaled(k), 1'b0);
         tick();
      end
      drive(1'b0, '0, '0, 1'b0);
      tick();
      tick();
      for (int j = 0; j < 14; j++) begin
         drive(1'b1, scaled(30 + j), scaled(j), j >= 2);
         tick();
         check_val("fullpop_level", level, 8);
         check_val("fullpop_ovf", ovfFlag, 0);
      end
      drive(1'b0, '0, '0, 1'b1);
      for (int j = 0; j < 12; j++) tick();

      // Empty pop attempts leave the FIFO untouched
      for (int j = 0; j < 10; j++) begin
         tick();
         check_val("emptypop_level", level, 0);
         check_val("emptypop_valid", outValid, 0);
      end
      drive(1'b1, scaled(77), scaled(-5), 1'b1);
      tick();
      drive(1'b0, '0, '0, 1'b0);
      tick();
      tick();
      check_val("after_empty_i", outI, 77);
      check_val("after_empty_q", outQ, 32'hfffffffb);
      outReady = 1'b1;
      tick();

      // Reset mid-stream: five queued, two in flight, one more on the reset edge
      for (int k = 0; k < 5; k++) begin
         drive(1'b1, scaled(100 + k), '0, 1'b0);
         tick();
      end
      drive(1'b0, '0, '0, 1'b0);
      tick();
      tick();
      check_val("mid_level", level, 5);
      for (int k = 0; k < 2; k++) begin
         drive(1'b1, scaled(200 + k), '0, 1'b0);
         tick();
      end
      drive(1'b1, scaled(300), '0, 1'b0);
      do_reset();
      drive(1'b0, '0, '0, 1'b1);
      check_val("mid_rst_level", level, 0);
      check_val("mid_rst_flags", {ovfFlag, satFlag}, 0);
      for (int j = 0; j < 8; j++) begin
         tick();
         check_val("mid_rst_valid", outValid, 0);
      end

      // Random traffic
      for (int j = 0; j < 800; j++) begin
         drive($urandom_range(0, 99) < 60, rnd56(), rnd56(), $urandom_range(0, 99) < 65);
         tick();
      end
      drive(1'b0, '0, '0, 1'b1);
      for (int j = 0; j < 12; j++) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
